// File: rtl/clr_en_pipe_reg_pkg.sv
// rtl/clr_en_pipe_reg_pkg.sv - shared helpers for the clearable enabled pipeline register
package clr_en_pipe_reg_pkg;

  // Occupancy counter must represent 0..depth inclusive.
  function automatic int cnt_width(input int depth);
    return $clog2(depth + 1);
  endfunction

  // Occupancy update selected each cycle from the two handshakes.
  typedef enum logic [1:0] {
    CNT_HOLD = 2'd0,
    CNT_INC  = 2'd1,
    CNT_DEC  = 2'd2
  } cnt_op_e;

endpackage

// File: rtl/clr_en_pipe_stage.sv
// rtl/clr_en_pipe_stage.sv - one data/valid slice with reset, flush, enable and load
module clr_en_pipe_stage #(
  parameter int               WIDTH    = 32,
  parameter logic [WIDTH-1:0] INI_DATA = WIDTH'(1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_en,
  input  logic             i_clr,
  input  logic             i_load,
  input  logic             i_src_vld,
  input  logic [WIDTH-1:0] i_src_dat,
  output logic             o_vld,
  output logic [WIDTH-1:0] o_dat
);

  logic             r_vld;
  logic [WIDTH-1:0] r_dat;

  // Reset and flush win; otherwise take the source when the slot frees, keeping data on bubbles.
  always_ff @(posedge clk) begin
    if (rst || i_clr) begin
      r_vld <= 1'b0;
      r_dat <= INI_DATA;
    end else if (i_en && i_load) begin
      r_vld <= i_src_vld;
      if (i_src_vld) begin
        r_dat <= i_src_dat;
      end
    end
  end

  assign o_vld = r_vld;
  assign o_dat = r_dat;

endmodule

// File: rtl/clr_en_pipe_reg.sv
// rtl/clr_en_pipe_reg.sv - bubble-collapsing valid/ready register pipeline with enable and flush
module clr_en_pipe_reg
  import clr_en_pipe_reg_pkg::*;
#(
  parameter int               WIDTH    = 32,
  parameter int               DEPTH    = 4,
  parameter logic [WIDTH-1:0] INI_DATA = WIDTH'(1)
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           i_en,
  input  logic                           i_clr,
  input  logic                           i_vld,
  output logic                           o_rdy,
  input  logic [WIDTH-1:0]               i_dat,
  output logic                           o_vld,
  input  logic                           i_rdy,
  output logic [WIDTH-1:0]               o_dat,
  output logic [cnt_width(DEPTH)-1:0]    o_cnt
);

  localparam int CW = cnt_width(DEPTH);

  logic [DEPTH:0]   w_rdy;
  logic [DEPTH-1:0] w_v;
  logic [WIDTH-1:0] w_d [DEPTH];
  logic             w_gate;
  logic             w_in_acc;
  logic             w_out_acc;
  cnt_op_e          w_op;
  logic [CW-1:0]    r_cnt;

  // Handshakes are only offered while running: not in reset, not flushing, enabled.
  assign w_gate    = i_en & ~i_clr & ~rst;
  assign w_rdy[DEPTH] = i_rdy;
  assign o_rdy     = w_gate & w_rdy[0];
  assign o_vld     = w_gate & w_v[DEPTH-1];
  assign o_dat     = w_d[DEPTH-1];
  assign w_in_acc  = i_vld & o_rdy;
  assign w_out_acc = o_vld & i_rdy;
  assign o_cnt     = r_cnt;

  for (genvar k = 0; k < DEPTH; k++) begin : g_stage
    // A slot can take new data if it is empty or its occupant moves on this cycle.
    assign w_rdy[k] = ~w_v[k] | w_rdy[k+1];

    if (k == 0) begin : g_head
      clr_en_pipe_stage #(
        .WIDTH    (WIDTH),
        .INI_DATA (INI_DATA)
      ) u_stage (
        .clk       (clk),
        .rst       (rst),
        .i_en      (i_en),
        .i_clr     (i_clr),
        .i_load    (w_rdy[k]),
        .i_src_vld (i_vld),
        .i_src_dat (i_dat),
        .o_vld     (w_v[k]),
        .o_dat     (w_d[k])
      );
    end else begin : g_body
      clr_en_pipe_stage #(
        .WIDTH    (WIDTH),
        .INI_DATA (INI_DATA)
      ) u_stage (
        .clk       (clk),
        .rst       (rst),
        .i_en      (i_en),
        .i_clr     (i_clr),
        .i_load    (w_rdy[k]),
        .i_src_vld (w_v[k-1]),
        .i_src_dat (w_d[k-1]),
        .o_vld     (w_v[k]),
        .o_dat     (w_d[k])
      );
    end
  end

  // Decide the occupancy change from the two accepts; both or neither leaves it unchanged.
  always_comb begin
    w_op = CNT_HOLD;
    if (w_in_acc && !w_out_acc) begin
      w_op = CNT_INC;
    end else if (w_out_acc && !w_in_acc) begin
      w_op = CNT_DEC;
    end
  end

  // Occupancy counter, cleared with the stages and bounded to 0..DEPTH.
  always_ff @(posedge clk) begin
    if (rst || i_clr) begin
      r_cnt <= '0;
    end else begin
      case (w_op)
        CNT_INC:  if (r_cnt != CW'(DEPTH)) r_cnt <= r_cnt + 1'b1;
        CNT_DEC:  if (r_cnt != '0)         r_cnt <= r_cnt - 1'b1;
        default:  r_cnt <= r_cnt;
      endcase
    end
  end

endmodule

// File: doc/clr_en_pipe_reg.md
CLR_EN_PIPE_REG -- requirements
Module: clr_en_pipe_reg

Interface
REQ-001 Parameter WIDTH, 32, data width in bits (>=1).
REQ-002 Parameter DEPTH, 4, number of register stages (>=1).
REQ-003 Parameter INI_DATA, WIDTH'(1), value loaded into every stage on reset or clear.
REQ-004 clk  input  1  clock, all state updates on rising edge.
REQ-005 rst  input  1  reset, synchronous, active-high.
REQ-006 i_en  input  1  global enable; 0 freezes all stages and blocks both handshakes.
REQ-007 i_clr  input  1  synchronous flush to INI_DATA / empty.
REQ-008 i_vld  input  1  upstream data valid.
REQ-009 o_rdy  output  1  upstream ready.
REQ-010 i_dat  input  WIDTH  upstream data.
REQ-011 o_vld  output  1  downstream data valid.
REQ-012 i_rdy  input  1  downstream ready.
REQ-013 o_dat  output  WIDTH  downstream data = last-stage data register.
REQ-014 o_cnt  output  $clog2(DEPTH+1)  number of valid stages.

Function
REQ-015 Each stage k (0..DEPTH-1) SHALL hold data d[k] and valid bit v[k]; stage 0 fed by i_dat, stage k by stage k-1.
REQ-016 Stage ready SHALL be rdy[k] = !v[k] | rdy[k+1], with rdy[DEPTH] = i_rdy (combinational, bubble-collapsing).
REQ-017 o_rdy SHALL equal i_en & !i_clr & rdy[0]; o_vld SHALL equal i_en & !i_clr & v[DEPTH-1].
REQ-018 Input accept = i_vld & o_rdy; output accept = o_vld & i_rdy.
REQ-019 With i_en=1, i_clr=0: stage k SHALL load from its source when rdy[k]=1, taking v[k] <= source valid; d[k] SHALL update only when source valid is 1, else hold.
REQ-020 With i_en=0 and i_clr=0: all d, v and o_cnt SHALL hold; no accept occurs.
REQ-021 i_clr=1 SHALL, at next edge, set all v to 0 and all d to INI_DATA regardless of i_en, i_vld, i_rdy; data in flight is discarded.
REQ-022 Latency: item accepted at edge t into an empty pipe with i_rdy=1 SHALL present o_vld=1 in the cycle after edge t+DEPTH-1.
REQ-023 Throughput: with i_vld=1, i_rdy=1, i_en=1 continuously, one item per cycle in and out, order preserved.
REQ-024 With i_rdy=0 the pipe SHALL compress bubbles until all DEPTH stages valid, then o_rdy=0.
REQ-025 Full pipe with i_rdy=1 SHALL accept input in the same cycle (simultaneous in/out).
REQ-026 o_cnt SHALL +1 on input-accept only, -1 on output-accept only, hold on both or neither; range 0..DEPTH, never wraps.
REQ-027 o_dat SHALL show d[DEPTH-1] unconditionally (INI_DATA when pipe never filled or after flush).
REQ-028 DEPTH=1 SHALL behave as a single enabled/clearable register slice with the same handshake.

Reset
REQ-029 rst=1 SHALL at next edge force all v=0, all d=INI_DATA, o_cnt=0; priority over i_clr and i_en.
REQ-030 During and after reset: o_vld=0, o_rdy=0 while rst=1 (i_clr path identical), o_dat=INI_DATA.
REQ-031 Reset asserted mid-transfer SHALL discard all held items; no partial state survives.

Structure
REQ-032 Package clr_en_pipe_reg_pkg SHALL hold the count-width function and any shared stage typedef (data+valid struct).
REQ-033 One sub-module clr_en_pipe_stage (one data/valid slice with clr, en, load, INI_DATA) SHALL be generated DEPTH times.
REQ-034 Occupancy counter and ready chain SHALL live in the top module.

Verification (WIDTH=32, DEPTH=4, INI_DATA=32'h1)
REQ-035 Reset: rst=1 two cycles -> o_dat=32'h1, o_vld=0, o_cnt=0, o_rdy=0; after release o_rdy=1.
REQ-036 Latency/stream: i_vld=1, i_rdy=1, i_dat=10,11,12.. -> o_vld rises 4 cycles after first accept, o_dat=10,11,12.. each cycle, o_cnt=4 steady.
REQ-037 Backpressure: i_rdy=0, push 5 items -> 4 accepted, o_rdy=0, o_cnt=4, o_dat=first item; i_rdy=1 -> items drain in order, o_rdy=1 same cycle.
REQ-038 Enable freeze: pipe holding 2 items, i_en=0 for 3 cycles with i_vld=1, i_rdy=1 -> o_vld=0, o_rdy=0, o_cnt=2 held; i_en=1 -> resumes with same order.
REQ-039 Clear: full pipe, i_clr=1 one cycle with i_vld=1 -> next cycle o_cnt=0, o_vld=0, o_dat=32'h1; input during clear not captured.
REQ-040 Random: random i_en, i_clr, i_vld, i_rdy, i_dat for 1000 cycles vs. queue model -> output order, o_cnt and o_dat match model every cycle.
